// File: rtl/parser_dispatch_arb.sv
// ---------------------------------------------------------------------------
// parser_dispatch_arb
//
// Purpose: shares one packet parser between NUM_REQ header-buffer
// requesters. A round-robin arbiter picks an owner, latches that owner's
// header window into hdr_out, pulses hdr_start to kick the parser, then waits
// for parse_done (or a timeout) and returns a one-cycle rel pulse to the owner.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   req          per-requester level request, held until its own rel pulse
//   hdr_in       concatenated header windows, requester i at slice i
//   parse_done   one-cycle completion pulse from the parser
//   hdr_out      registered header window presented to the parser
//   hdr_start    one-cycle start pulse to the parser
//   grant        one-hot owner of the parser, all-zero when idle
//   active_id    index of the current owner
//   busy         high whenever the FSM is not in IDLE
//   rel          one-cycle completion pulse to the owning requester
//   timeout_err  pulses with rel when the service ended by timeout
// ---------------------------------------------------------------------------
module parser_dispatch_arb #(
  parameter int NUM_REQ      = 4,
  parameter int HEADER_BYTES = 192,
  parameter int TIMEOUT      = 32,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*8*HEADER_BYTES-1:0] hdr_in,
  input  logic                              parse_done,
  output logic [8*HEADER_BYTES-1:0]         hdr_out,
  output logic                              hdr_start,
  output logic [NUM_REQ-1:0]                grant,
  output logic [ID_W-1:0]                   active_id,
  output logic                              busy,
  output logic [NUM_REQ-1:0]                rel,
  output logic                              timeout_err
);

  localparam int HDR_W = 8 * HEADER_BYTES;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_inc;
  logic [ID_W-1:0]   last_id;

  // Per-requester view of the packed header bus.
  logic [HDR_W-1:0]  slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice[gi] = hdr_in[gi*HDR_W +: HDR_W];
    end
  endgenerate

  // Round-robin pick. Candidates are visited from the farthest offset down
  // to offset 1 past last_id, so the nearest requesting index is the last
  // one written and therefore wins.
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0] win_grant;
  logic [ID_W-1:0]    cand;

  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_grant = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_id) + k) % NUM_REQ);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
        win_grant = NUM_REQ'(1) << cand;
      end
    end
  end

  // The timeout test looks at the post-increment count, so the DONE cycle
  // lands exactly TIMEOUT cycles after the hdr_start cycle.
  assign wait_inc = wait_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      last_id     <= ID_LAST;
      hdr_out     <= '0;
      hdr_start   <= 1'b0;
      grant       <= '0;
      active_id   <= '0;
      busy        <= 1'b0;
      rel         <= '0;
      timeout_err <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised only on the transition
      // into the single state in which it may be high.
      hdr_start   <= 1'b0;
      rel         <= '0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (win_valid) begin
            hdr_out   <= slice[win_id];
            grant     <= win_grant;
            active_id <= win_id;
            busy      <= 1'b1;
            hdr_start <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          wait_cnt <= wait_inc;
          // A completion arriving on the timeout cycle counts as normal.
          if (parse_done) begin
            rel         <= grant;
            timeout_err <= 1'b0;
            state       <= DONE;
          end else if (wait_inc == CNT_LAST) begin
            rel         <= grant;
            timeout_err <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          last_id <= active_id;
          grant   <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
